aib_cfg_regfile: RTL

Parametrised, double-buffered configuration register file for the AIB top level. It is driven by the UART debug port's APB-style master interface and holds per-IO, per-channel, UMAI and chip configuration in shadow registers. Shadow contents are copied atomically to active registers on a commit command, and only the active registers drive the configuration outputs. A sticky lock freezes the configuration, and an error response flags illegal accesses.

---
 rtl/aib_cfg_regfile_if.sv | 20 ++
 rtl/aib_cfg_regfile.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/aib_cfg_regfile_if.sv
// APB-style register bus between the UART debug master and the AIB config register file.
interface aib_cfg_regfile_if;
   logic        i_penable;
   logic        i_pwrite;
   logic [31:0] i_paddr;
   logic [31:0] i_pwdata;
   logic        o_pready;
   logic [31:0] o_prdata;
   logic        o_pslverr;

   modport master (
      output i_penable, i_pwrite, i_paddr, i_pwdata,
      input  o_pready, o_prdata, o_pslverr
   );

   modport slave (
      input  i_penable, i_pwrite, i_paddr, i_pwdata,
      output o_pready, o_prdata, o_pslverr
   );
endinterface

// File: rtl/aib_cfg_regfile.sv
// Double-buffered AIB configuration register file: shadow registers written over the bus,
// copied atomically to the active (output-driving) registers on commit, with sticky lock.
module aib_cfg_regfile #(
   parameter int unsigned NumChannels = 6,
   parameter int unsigned NumIos      = 96
) (
   input  logic                            i_clk,
   input  logic                            i_rst_n,
   aib_cfg_regfile_if.slave                bus,
   output logic [NumChannels*NumIos*9-1:0] o_iob_cfg,
   output logic [NumChannels*5-1:0]        o_chn_cfg,
   output logic [12:0]                     o_umai_cfg,
   output logic                            o_conf_done,
   output logic                            o_locked
);

   localparam int unsigned NumEnt = NumChannels * NumIos;
   localparam int unsigned EntW   = (NumEnt > 1) ? $clog2(NumEnt) : 1;
   localparam int unsigned ChnW   = (NumChannels > 1) ? $clog2(NumChannels) : 1;

   localparam logic [1:0] RegIob  = 2'd0;
   localparam logic [1:0] RegChn  = 2'd1;
   localparam logic [1:0] RegGlb  = 2'd2;
   localparam logic [7:0] IdxUmai = 8'd0;
   localparam logic [7:0] IdxChip = 8'd1;
   localparam logic [7:0] IdxCtrl = 8'd2;
   localparam logic [7:0] IdxStat = 8'd3;

   logic [8:0]  iob_sh_q  [NumEnt];
   logic [8:0]  iob_sh_d  [NumEnt];
   logic [8:0]  iob_act_q [NumEnt];
   logic [8:0]  iob_act_d [NumEnt];
   logic [4:0]  chn_sh_q  [NumChannels];
   logic [4:0]  chn_sh_d  [NumChannels];
   logic [4:0]  chn_act_q [NumChannels];
   logic [4:0]  chn_act_d [NumChannels];
   logic [12:0] umai_sh_q, umai_sh_d, umai_act_q, umai_act_d;
   logic        chip_sh_q, chip_sh_d, chip_act_q, chip_act_d;
   logic        lock_q, lock_d;
   logic [7:0]  commit_cnt_q, commit_cnt_d;
   logic [7:0]  err_cnt_q, err_cnt_d;
   logic        wait_q, wait_d;
   logic [31:0] prdata_q, prdata_d;
   logic        pslverr_q, pslverr_d;

   logic            pen, wr, rd;
   logic [1:0]      region;
   logic [3:0]      chn;
   logic [7:0]      idx;
   logic [31:0]     chn32, idx32;
   logic [EntW-1:0] ent;
   logic [ChnW-1:0] chn_sel;
   logic            err, commit;
   logic            sel_iob, sel_chn, sel_umai, sel_chip, sel_ctrl;
   logic [31:0]     rdata;
   logic            unused_bits;

   // Reset forces the bus view to idle even if the master still holds penable.
   assign pen     = bus.i_penable & i_rst_n;
   assign wr      = pen & bus.i_pwrite;
   assign rd      = pen & ~bus.i_pwrite;
   assign region  = bus.i_paddr[15:14];
   assign chn     = bus.i_paddr[13:10];
   assign idx     = bus.i_paddr[9:2];
   assign chn32   = {28'd0, chn};
   assign idx32   = {24'd0, idx};
   assign ent     = EntW'(chn32 * NumIos + idx32);
   assign chn_sel = ChnW'(chn32);

   assign unused_bits = ^{bus.i_paddr[31:16], bus.i_paddr[1:0], bus.i_pwdata[31:13]};

   always_comb begin : decode
      err      = 1'b0;
      rdata    = '0;
      sel_iob  = 1'b0;
      sel_chn  = 1'b0;
      sel_umai = 1'b0;
      sel_chip = 1'b0;
      sel_ctrl = 1'b0;
      case (region)
         RegIob: begin
            if (chn32 >= NumChannels || idx32 >= NumIos) begin
               err = 1'b1;
            end else begin
               sel_iob = 1'b1;
               rdata   = {23'd0, iob_sh_q[ent]};
            end
         end
         RegChn: begin
            if (chn32 >= NumChannels || idx != 8'd0) begin
               err = 1'b1;
            end else begin
               sel_chn = 1'b1;
               rdata   = {27'd0, chn_sh_q[chn_sel]};
            end
         end
         RegGlb: begin
            if (chn != 4'd0) begin
               err = 1'b1;
            end else begin
               case (idx)
                  IdxUmai: begin
                     sel_umai = 1'b1;
                     rdata    = {19'd0, umai_sh_q};
                  end
                  IdxChip: begin
                     sel_chip = 1'b1;
                     rdata    = {31'd0, chip_sh_q};
                  end
                  IdxCtrl: begin
                     sel_ctrl = 1'b1;
                     rdata    = {30'd0, lock_q, 1'b0};
                  end
                  IdxStat: begin
                     rdata = {16'd0, err_cnt_q, commit_cnt_q};
                     err   = bus.i_pwrite;
                  end
                  default: err = 1'b1;
               endcase
            end
         end
         default: err = 1'b1;
      endcase
      if (bus.i_pwrite && lock_q && (sel_iob || sel_chn || sel_umai || sel_chip || sel_ctrl)) begin
         err = 1'b1;
      end
      if (err) begin
         rdata = '0;
      end
   end

   always_comb begin : next_state
      iob_sh_d     = iob_sh_q;
      iob_act_d    = iob_act_q;
      chn_sh_d     = chn_sh_q;
      chn_act_d    = chn_act_q;
      umai_sh_d    = umai_sh_q;
      umai_act_d   = umai_act_q;
      chip_sh_d    = chip_sh_q;
      chip_act_d   = chip_act_q;
      lock_d       = lock_q;
      commit_cnt_d = commit_cnt_q;
      err_cnt_d    = err_cnt_q;
      wait_d       = rd & ~wait_q;
      prdata_d     = prdata_q;
      pslverr_d    = pslverr_q;
      commit       = 1'b0;

      if (wr && !err) begin
         if (sel_iob)  iob_sh_d[ent]     = bus.i_pwdata[8:0];
         if (sel_chn)  chn_sh_d[chn_sel] = bus.i_pwdata[4:0];
         if (sel_umai) umai_sh_d         = bus.i_pwdata[12:0];
         if (sel_chip) chip_sh_d         = bus.i_pwdata[0];
         if (sel_ctrl) begin
            commit = bus.i_pwdata[0];
            lock_d = lock_q | bus.i_pwdata[1];
         end
      end

      // Commit copies the current (pre-write) shadow state.
      if (commit) begin
         iob_act_d  = iob_sh_q;
         chn_act_d  = chn_sh_q;
         umai_act_d = umai_sh_q;
         chip_act_d = chip_sh_q;
         if (commit_cnt_q != 8'hFF) commit_cnt_d = commit_cnt_q + 8'd1;
      end

      if (rd && !wait_q) begin
         prdata_d  = rdata;
         pslverr_d = err;
      end

      if (((wr && err) || (rd && wait_q && pslverr_q)) && err_cnt_q != 8'hFF) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         iob_sh_q     <= '{default: '0};
         iob_act_q    <= '{default: '0};
         chn_sh_q     <= '{default: '0};
         chn_act_q    <= '{default: '0};
         umai_sh_q    <= '0;
         umai_act_q   <= '0;
         chip_sh_q    <= 1'b0;
         chip_act_q   <= 1'b0;
         lock_q       <= 1'b0;
         commit_cnt_q <= '0;
         err_cnt_q    <= '0;
         wait_q       <= 1'b0;
         prdata_q     <= '0;
         pslverr_q    <= 1'b0;
      end else begin
         iob_sh_q     <= iob_sh_d;
         iob_act_q    <= iob_act_d;
         chn_sh_q     <= chn_sh_d;
         chn_act_q    <= chn_act_d;
         umai_sh_q    <= umai_sh_d;
         umai_act_q   <= umai_act_d;
         chip_sh_q    <= chip_sh_d;
         chip_act_q   <= chip_act_d;
         lock_q       <= lock_d;
         commit_cnt_q <= commit_cnt_d;
         err_cnt_q    <= err_cnt_d;
         wait_q       <= wait_d;
         prdata_q     <= prdata_d;
         pslverr_q    <= pslverr_d;
      end
   end

   assign bus.o_pready  = ~rd | wait_q;
   assign bus.o_pslverr = wr ? err : (rd & wait_q & pslverr_q);
   assign bus.o_prdata  = prdata_q;

   always_comb begin : cfg_out
      o_iob_cfg = '0;
      for (int unsigned e = 0; e < NumEnt; e++) begin
         o_iob_cfg[e*9 +: 9] = iob_act_q[e];
      end
      o_chn_cfg = '0;
      for (int unsigned c = 0; c < NumChannels; c++) begin
         o_chn_cfg[c*5 +: 5] = chn_act_q[c];
      end
   end

   assign o_umai_cfg  = umai_act_q;
   assign o_conf_done = chip_act_q;
   assign o_locked    = lock_q;

endmodule
